// File: rtl/gap_junction_pkg.sv
// Shared types and widths for the gap-junction result-stream sink.
package gap_junction_pkg;

    localparam int GJ_DATA_W    = 32;
    localparam int GJ_COUNT_W   = 16;
    localparam int GJ_ERR_W     = 8;
    localparam int GJ_TIMEOUT_W = 20;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } gj_state_e;

endpackage

// File: rtl/gap_junction_stream_sink_ready_shaper.sv
// Produces the sink TREADY from the RUN enable and a rotating 8-phase mask.
module axis_ready_shaper
    import gap_junction_pkg::*;
#(
    parameter logic [7:0] Ready_Pattern = 8'hFF
) (
    input  logic clk,
    input  logic reset,
    input  logic run_en,
    output logic tready
);

    logic [2:0] phase;

    // Phase advances once per RUN cycle and wraps naturally from 7 to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= 3'd0;
        end else if (run_en) begin
            phase <= phase + 3'd1;
        end
    end

    // Ready depends only on registered state, never on TVALID or TLAST.
    always_comb begin
        tready = run_en & Ready_Pattern[phase];
    end

endmodule

// File: rtl/gap_junction_stream_sink.sv
// Result-stream sink: checks TLAST framing, sums each frame, stops after a
// target number of frames and flags upstream stalls.
//
// state  | meaning
// S_IDLE | start delay after reset, TREADY held low
// S_RUN  | accepting words under the ready pattern
// S_DONE | target reached, TREADY low until reset
module gap_junction_stream_sink
    import gap_junction_pkg::*;
#(
    parameter int unsigned                 Frame_Length   = 16,
    parameter logic [GJ_COUNT_W-1:0]       Frame_Target   = 16'd100,
    parameter logic [15:0]                 Start_Delay    = 16'd50,
    parameter logic [7:0]                  Ready_Pattern  = 8'hFF,
    parameter logic [GJ_TIMEOUT_W-1:0]     Timeout_Cycles = 20'd20000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [GJ_DATA_W-1:0]  output_r_TDATA_0,
    input  logic                  output_r_TVALID_0,
    input  logic                  output_r_TLAST_0,
    output logic                  output_r_TREADY_0,
    output logic [GJ_COUNT_W-1:0] frame_count,
    output logic [GJ_DATA_W-1:0]  frame_sum,
    output logic [GJ_ERR_W-1:0]   err_count,
    output logic                  done,
    output logic                  timeout
);

    localparam logic [GJ_COUNT_W-1:0] LAST_IDX = GJ_COUNT_W'(Frame_Length - 1);

    gj_state_e               state;
    logic [15:0]             delay_cnt;
    logic [GJ_COUNT_W-1:0]   word_idx;
    logic [GJ_DATA_W-1:0]    sum_acc;
    logic [GJ_TIMEOUT_W-1:0] idle_cnt;
    logic [GJ_COUNT_W-1:0]   frame_count_inc;
    logic                    run_en;
    logic                    hs;
    logic                    at_last_idx;
    logic                    close_frame;
    logic                    hits_target;
    logic                    delay_expired;

    assign run_en          = (state == S_RUN);
    assign hs              = output_r_TVALID_0 && output_r_TREADY_0;
    assign at_last_idx     = (word_idx == LAST_IDX);
    assign close_frame     = hs && output_r_TLAST_0;
    assign frame_count_inc = frame_count + GJ_COUNT_W'(1);
    assign hits_target     = close_frame && (frame_count_inc == Frame_Target);
    assign delay_expired   = (Start_Delay == 16'd0) || (delay_cnt == Start_Delay - 16'd1);

    axis_ready_shaper #(
        .Ready_Pattern(Ready_Pattern)
    ) u_ready_shaper (
        .clk    (clk),
        .reset  (reset),
        .run_en (run_en),
        .tready (output_r_TREADY_0)
    );

    // Sequencing: start delay, then run until the closing transfer of the target frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            delay_cnt <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (delay_expired) state <= S_RUN;
                    else               delay_cnt <= delay_cnt + 16'd1;
                end
                S_RUN: begin
                    if (hits_target) state <= S_DONE;
                end
                S_DONE:  state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Framing check and accumulation; an early TLAST still closes the frame to resync.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_idx    <= '0;
            sum_acc     <= '0;
            frame_sum   <= '0;
            frame_count <= '0;
            err_count   <= '0;
            done        <= 1'b0;
        end else if (hs) begin
            if (output_r_TLAST_0) begin
                frame_sum   <= sum_acc + output_r_TDATA_0;
                frame_count <= frame_count_inc;
                sum_acc     <= '0;
                word_idx    <= '0;
                if (!at_last_idx && (err_count != '1)) err_count <= err_count + GJ_ERR_W'(1);
                if (hits_target) done <= 1'b1;
            end else if (at_last_idx) begin
                // Missing TLAST: the overlong frame is dropped, not reported as a frame.
                if (err_count != '1) err_count <= err_count + GJ_ERR_W'(1);
                sum_acc  <= '0;
                word_idx <= '0;
            end else begin
                sum_acc  <= sum_acc + output_r_TDATA_0;
                word_idx <= word_idx + GJ_COUNT_W'(1);
            end
        end
    end

    // Stall watchdog: counts RUN cycles without a handshake, saturating at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else if (run_en) begin
            if (hs) begin
                idle_cnt <= '0;
            end else if (idle_cnt != Timeout_Cycles) begin
                idle_cnt <= idle_cnt + GJ_TIMEOUT_W'(1);
                if (idle_cnt + GJ_TIMEOUT_W'(1) == Timeout_Cycles) timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gap_junction_stream_sink.sv
// Self-checking bench for gap_junction_stream_sink: two instances (full-rate
// and alternating ready) driven from shared inputs, checked every cycle
// against a frame-level reference model.
module tb_gap_junction_stream_sink;

    localparam int FL     = 4;
    localparam int SD     = 50;
    localparam int TARGET = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;

    logic        a_tready, b_tready;
    logic [15:0] a_fcount, b_fcount;
    logic [31:0] a_fsum, b_fsum;
    logic [7:0]  a_ecount, b_ecount;
    logic        a_done, b_done;
    logic        a_tmo, b_tmo;

    always #5 clk = ~clk;

    gap_junction_stream_sink #(
        .Frame_Length(FL), .Frame_Target(16'd2), .Start_Delay(16'd50),
        .Ready_Pattern(8'hFF), .Timeout_Cycles(20'd100)
    ) dut_a (
        .clk(clk), .reset(reset),
        .output_r_TDATA_0(tdata), .output_r_TVALID_0(tvalid), .output_r_TLAST_0(tlast),
        .output_r_TREADY_0(a_tready), .frame_count(a_fcount), .frame_sum(a_fsum),
        .err_count(a_ecount), .done(a_done), .timeout(a_tmo)
    );

    gap_junction_stream_sink #(
        .Frame_Length(FL), .Frame_Target(16'd2), .Start_Delay(16'd50),
        .Ready_Pattern(8'h55), .Timeout_Cycles(20'd20000)
    ) dut_b (
        .clk(clk), .reset(reset),
        .output_r_TDATA_0(tdata), .output_r_TVALID_0(tvalid), .output_r_TLAST_0(tlast),
        .output_r_TREADY_0(b_tready), .frame_count(b_fcount), .frame_sum(b_fsum),
        .err_count(b_ecount), .done(b_done), .timeout(b_tmo)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] d;
        bit          l;
    } word_t;

    word_t       stim[$];
    logic [31:0] m_frame[$];
    int          m_count;
    int          m_err;
    logic [31:0] m_fsum;
    bit          m_done;
    int          m_idle;
    bit          m_tmo;
    int          since_rst;

    function automatic logic o_rdy(input int sel);
        return sel != 0 ? b_tready : a_tready;
    endfunction
    function automatic logic [15:0] o_fc(input int sel);
        return sel != 0 ? b_fcount : a_fcount;
    endfunction
    function automatic logic [31:0] o_fs(input int sel);
        return sel != 0 ? b_fsum : a_fsum;
    endfunction
    function automatic logic [7:0] o_ec(input int sel);
        return sel != 0 ? b_ecount : a_ecount;
    endfunction
    function automatic logic o_done(input int sel);
        return sel != 0 ? b_done : a_done;
    endfunction
    function automatic logic o_tmo(input int sel);
        return sel != 0 ? b_tmo : a_tmo;
    endfunction

    task automatic model_reset();
        m_frame.delete();
        m_count   = 0;
        m_err     = 0;
        m_fsum    = '0;
        m_done    = 0;
        m_idle    = 0;
        m_tmo     = 0;
        since_rst = 0;
    endtask

    // Frame-level reference: a frame is the list of words since the last close.
    task automatic model_push(input logic [31:0] d, input bit l);
        logic [31:0] s;
        if (l) begin
            s = d;
            foreach (m_frame[i]) s = s + m_frame[i];
            m_fsum = s;
            m_count++;
            if (m_frame.size() != FL - 1 && m_err < 255) m_err++;
            m_frame.delete();
            if (m_count == TARGET) m_done = 1;
        end else if (m_frame.size() == FL - 1) begin
            if (m_err < 255) m_err++;
            m_frame.delete();
        end else begin
            m_frame.push_back(d);
        end
    endtask

    // One clock of the selected DUT: check ready, advance model, check status after the edge.
    task automatic cycle(input int sel, output bit hs);
        logic [7:0] pat;
        int         to;
        bit         running;
        logic       exp_rdy;
        pat     = (sel != 0) ? 8'h55 : 8'hFF;
        to      = (sel != 0) ? 20000 : 100;
        running = (since_rst >= SD) && !m_done;
        exp_rdy = running ? pat[(since_rst - SD) % 8] : 1'b0;
        checks++;
        if (o_rdy(sel) !== exp_rdy) begin
            errors++;
            $display("FAIL tready dut=%0d cyc=%0d got=%b exp=%b", sel, since_rst, o_rdy(sel), exp_rdy);
        end
        hs = tvalid && exp_rdy;
        if (running) begin
            if (hs) m_idle = 0;
            else begin
                if (m_idle < to) m_idle++;
                if (m_idle >= to) m_tmo = 1;
            end
        end
        if (hs) model_push(tdata, tlast);
        @(posedge clk);
        #1;
        since_rst++;
        checks += 5;
        if (o_fc(sel) !== 16'(m_count)) begin
            errors++;
            $display("FAIL frame_count dut=%0d cyc=%0d got=%0d exp=%0d", sel, since_rst, o_fc(sel), m_count);
        end
        if (o_fs(sel) !== m_fsum) begin
            errors++;
            $display("FAIL frame_sum dut=%0d cyc=%0d got=%0d exp=%0d", sel, since_rst, o_fs(sel), m_fsum);
        end
        if (o_ec(sel) !== 8'(m_err)) begin
            errors++;
            $display("FAIL err_count dut=%0d cyc=%0d got=%0d exp=%0d", sel, since_rst, o_ec(sel), m_err);
        end
        if (o_done(sel) !== m_done) begin
            errors++;
            $display("FAIL done dut=%0d cyc=%0d got=%b exp=%b", sel, since_rst, o_done(sel), m_done);
        end
        if (o_tmo(sel) !== m_tmo) begin
            errors++;
            $display("FAIL timeout dut=%0d cyc=%0d got=%b exp=%b", sel, since_rst, o_tmo(sel), m_tmo);
        end
    endtask

    task automatic idle(input int sel, input int n);
        bit hs;
        tvalid = 1'b0;
        tlast  = 1'b0;
        for (int i = 0; i < n; i++) cycle(sel, hs);
    endtask

    // Present the queued words in order, with gap_pct percent of cycles left invalid.
    task automatic run_stream(input int sel, input int gap_pct, input int budget);
        bit hs;
        int n;
        n = 0;
        while (stim.size() > 0 && !m_done && n < budget) begin
            tvalid = ($urandom_range(99) >= gap_pct);
            tdata  = stim[0].d;
            tlast  = stim[0].l;
            cycle(sel, hs);
            if (hs) void'(stim.pop_front());
            n++;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        checks++;
        if (stim.size() != 0 && !m_done) begin
            errors++;
            $display("FAIL stream_budget dut=%0d got=%0d_left exp=0_left", sel, stim.size());
        end
        stim.delete();
    endtask

    task automatic push_word(input logic [31:0] d, input bit l);
        word_t w;
        w.d = d;
        w.l = l;
        stim.push_back(w);
    endtask

    task automatic do_reset();
        tvalid = 1'b0;
        tlast  = 1'b0;
        tdata  = '0;
        reset  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        tvalid = 1'b1;
        tlast  = 1'b1;
        tdata  = 32'hDEAD_BEEF;
        reset  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if ({o_rdy(s), o_fc(s), o_fs(s), o_ec(s), o_done(s), o_tmo(s)} !== '0) begin
                errors++;
                $display("FAIL reset_state dut=%0d got=%b_%0d_%0d_%0d_%b_%b exp=all_zero",
                         s, o_rdy(s), o_fc(s), o_fs(s), o_ec(s), o_done(s), o_tmo(s));
            end
        end
    endtask

    task automatic test_nominal();
        int first_rdy;
        do_reset();
        first_rdy = -1;
        tvalid = 1'b0;
        while (since_rst < SD + 2) begin
            if (o_rdy(0) === 1'b1 && first_rdy < 0) first_rdy = since_rst;
            idle(0, 1);
        end
        checks++;
        if (first_rdy != SD) begin
            errors++;
            $display("FAIL first_tready got=%0d exp=%0d", first_rdy, SD);
        end
        push_word(1, 0); push_word(2, 0); push_word(3, 0); push_word(4, 1);
        run_stream(0, 0, 50);
        checks++;
        if (a_fsum !== 32'd10) begin
            errors++;
            $display("FAIL nominal_sum1 got=%0d exp=10", a_fsum);
        end
        push_word(10, 0); push_word(20, 0); push_word(30, 0); push_word(40, 1);
        run_stream(0, 0, 50);
        checks++;
        if ({a_fsum, a_fcount, a_ecount, a_done} !== {32'd100, 16'd2, 8'd0, 1'b1}) begin
            errors++;
            $display("FAIL nominal_final got=sum%0d_cnt%0d_err%0d_done%b exp=sum100_cnt2_err0_done1",
                     a_fsum, a_fcount, a_ecount, a_done);
        end
        // Keep offering words after done; none may be accepted.
        push_word(7, 0); push_word(8, 1);
        tvalid = 1'b1;
        begin
            bit hs;
            tdata = 32'd7;
            for (int i = 0; i < 6; i++) cycle(0, hs);
        end
        tvalid = 1'b0;
        stim.delete();
    endtask

    task automatic test_backpressure();
        logic [31:0] s2;
        logic [31:0] d;
        do_reset();
        s2 = '0;
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            if (i >= 4) s2 = s2 + d;
            push_word(d, (i % 4) == 3);
        end
        run_stream(1, 0, 200);
        checks++;
        if (since_rst != SD + 15) begin
            errors++;
            $display("FAIL backpressure_cycles got=%0d exp=%0d", since_rst, SD + 15);
        end
        checks++;
        if ({b_fsum, b_fcount, b_done} !== {s2, 16'd2, 1'b1}) begin
            errors++;
            $display("FAIL backpressure_final got=sum%0h_cnt%0d_done%b exp=sum%0h_cnt2_done1",
                     b_fsum, b_fcount, b_done, s2);
        end
    endtask

    task automatic test_early_last();
        do_reset();
        push_word(5, 0); push_word(6, 1);
        run_stream(0, 0, 100);
        checks++;
        if ({a_fsum, a_ecount} !== {32'd11, 8'd1}) begin
            errors++;
            $display("FAIL early_first got=sum%0d_err%0d exp=sum11_err1", a_fsum, a_ecount);
        end
        push_word(1, 0); push_word(1, 0); push_word(1, 0); push_word(1, 1);
        run_stream(0, 0, 50);
        checks++;
        if ({a_fsum, a_fcount, a_ecount} !== {32'd4, 16'd2, 8'd1}) begin
            errors++;
            $display("FAIL early_final got=sum%0d_cnt%0d_err%0d exp=sum4_cnt2_err1",
                     a_fsum, a_fcount, a_ecount);
        end
    endtask

    task automatic test_missing_last();
        do_reset();
        for (int i = 0; i < 4; i++) push_word($urandom, 0);
        push_word(2, 0); push_word(2, 0); push_word(2, 0); push_word(2, 1);
        run_stream(0, 20, 200);
        checks++;
        if ({a_fsum, a_fcount, a_ecount, a_done} !== {32'd8, 16'd1, 8'd1, 1'b0}) begin
            errors++;
            $display("FAIL missing_final got=sum%0d_cnt%0d_err%0d_done%b exp=sum8_cnt1_err1_done0",
                     a_fsum, a_fcount, a_ecount, a_done);
        end
    endtask

    task automatic test_timeout();
        int rise;
        bit hs;
        do_reset();
        for (int i = 0; i < 4; i++) push_word($urandom, i == 3);
        run_stream(0, 0, 100);
        rise = -1;
        for (int i = 1; i <= 120; i++) begin
            idle(0, 1);
            if (a_tmo === 1'b1 && rise < 0) rise = i;
        end
        checks++;
        if (rise != 100) begin
            errors++;
            $display("FAIL timeout_rise got=%0d exp=100", rise);
        end
        // Separate run: a handshake on the 99th idle cycle restarts the count.
        do_reset();
        for (int i = 0; i < 4; i++) push_word($urandom, i == 3);
        run_stream(0, 0, 100);
        idle(0, 98);
        tvalid = 1'b1;
        tlast  = 1'b0;
        tdata  = $urandom;
        cycle(0, hs);
        idle(0, 5);
        checks++;
        if (a_tmo !== 1'b0) begin
            errors++;
            $display("FAIL timeout_saved got=%b exp=0", a_tmo);
        end
        idle(0, 100);
    endtask

    task automatic test_mid_reset();
        do_reset();
        push_word(9, 0); push_word(9, 0); push_word(9, 0); push_word(9, 1);
        push_word(3, 0); push_word(3, 0);
        run_stream(0, 0, 100);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if ({a_tready, a_fcount, a_fsum, a_ecount, a_done, a_tmo} !== '0) begin
            errors++;
            $display("FAIL mid_reset got=%b_%0d_%0d_%0d_%b_%b exp=all_zero",
                     a_tready, a_fcount, a_fsum, a_ecount, a_done, a_tmo);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        push_word(1, 0); push_word(2, 0); push_word(3, 0); push_word(4, 1);
        run_stream(0, 0, 100);
        checks++;
        if ({a_fsum, a_ecount, a_fcount} !== {32'd10, 8'd0, 16'd1}) begin
            errors++;
            $display("FAIL mid_reset_resume got=sum%0d_err%0d_cnt%0d exp=sum10_err0_cnt1",
                     a_fsum, a_ecount, a_fcount);
        end
    endtask

    task automatic test_random();
        int kind;
        int len;
        for (int sel = 0; sel < 2; sel++) begin
            for (int it = 0; it < 3; it++) begin
                do_reset();
                for (int f = 0; f < 4; f++) begin
                    kind = $urandom_range(9);
                    if (kind == 0) begin
                        len = $urandom_range(FL - 1, 2);
                        for (int w = 0; w < len; w++) push_word($urandom, w == len - 1);
                    end else if (kind == 1) begin
                        for (int w = 0; w < FL; w++) push_word($urandom, 0);
                    end else begin
                        for (int w = 0; w < FL; w++) push_word($urandom, w == FL - 1);
                    end
                end
                run_stream(sel, 30, 600);
                idle(sel, 4);
            end
        end
    endtask

    initial begin
        tvalid = 1'b0;
        tlast  = 1'b0;
        tdata  = '0;
        reset  = 1'b1;
        model_reset();
        test_reset();
        test_nominal();
        test_backpressure();
        test_early_last();
        test_missing_last();
        test_timeout();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=no_finish exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
